// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit: FSM encoding,
// bypass select base value, counter width and a saturating increment helper.
package fwd_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    SB_WAIT  = 2'd2
  } hz_state_e;

  localparam int SEL_RF = 0;
  localparam int CNT_W  = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-side signal bundle of the forwarding/hazard unit; master drives the
// pipeline inputs, slave (the unit) drives selects, stall and debug outputs.
interface forward_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NFWD  = 2,
  parameter int SW    = 2
);
  logic [AW-1:0]      ex_rs;
  logic [AW-1:0]      ex_rt;
  logic [NFWD-1:0]    stg_we;
  logic [NFWD*AW-1:0] stg_rd;
  logic [SW-1:0]      fwd_sel_a;
  logic [SW-1:0]      fwd_sel_b;
  logic               id_valid;
  logic [AW-1:0]      id_rs;
  logic [AW-1:0]      id_rt;
  logic [AW-1:0]      id_rd;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               id_we;
  logic               id_is_ll;
  logic               ex_we;
  logic               ex_is_load;
  logic [AW-1:0]      ex_rd;
  logic               ll_done_valid;
  logic [AW-1:0]      ll_done_rd;
  logic               stall;
  logic [1:0]         hz_state;
  logic [NREGS-1:0]   sb_busy;
  logic [CNT_W-1:0]   lu_stall_cnt;
  logic [CNT_W-1:0]   sb_stall_cnt;

  modport master (
    output ex_rs, ex_rt, stg_we, stg_rd, id_valid, id_rs, id_rt, id_rd,
           id_rs_used, id_rt_used, id_we, id_is_ll, ex_we, ex_is_load, ex_rd,
           ll_done_valid, ll_done_rd,
    input  fwd_sel_a, fwd_sel_b, stall, hz_state, sb_busy, lu_stall_cnt,
           sb_stall_cnt
  );

  modport slave (
    input  ex_rs, ex_rt, stg_we, stg_rd, id_valid, id_rs, id_rt, id_rd,
           id_rs_used, id_rt_used, id_we, id_is_ll, ex_we, ex_is_load, ex_rd,
           ll_done_valid, ll_done_rd,
    output fwd_sel_a, fwd_sel_b, stall, hz_state, sb_busy, lu_stall_cnt,
           sb_stall_cnt
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations: one set and one clear
// per cycle, set wins on collision, register 0 is never marked busy.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;

  // Next busy vector: set overrides clear, clearing an idle bit is harmless
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt_s[i] = (set_en && (set_idx == AW'(i))) ? 1'b1 :
                      (clr_en && (clr_idx == AW'(i))) ? 1'b0 : busy_r[i];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding (youngest producer wins), load-use and scoreboard hazard
// detection, stall FSM and stall counters. Counters exist only when
// FWD_PERF_CNT_EN is defined; otherwise the counter outputs read zero.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NFWD  = 2,
  parameter int SW    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  forward_hazard_unit_if.slave bus
);

  logic [SW-1:0]    fwd_a_s;
  logic [SW-1:0]    fwd_b_s;
  logic             lu_s;
  logic             sb_s;
  logic             stall_s;
  logic             set_en_s;
  logic [NREGS-1:0] busy_s;
  hz_state_e        state_r;
  hz_state_e        state_nxt_s;

  // Bypass selects: scan oldest to youngest so the youngest match overrides
  always_comb begin
    fwd_a_s = SW'(SEL_RF);
    fwd_b_s = SW'(SEL_RF);
    for (int k = NFWD; k >= 1; k--) begin
      fwd_a_s = (bus.stg_we[k-1] && (bus.stg_rd[(k-1)*AW +: AW] != {AW{1'b0}}) &&
                 (bus.stg_rd[(k-1)*AW +: AW] == bus.ex_rs)) ? SW'(k) : fwd_a_s;
      fwd_b_s = (bus.stg_we[k-1] && (bus.stg_rd[(k-1)*AW +: AW] != {AW{1'b0}}) &&
                 (bus.stg_rd[(k-1)*AW +: AW] == bus.ex_rt)) ? SW'(k) : fwd_b_s;
    end
  end

  assign lu_s = bus.id_valid && bus.ex_we && bus.ex_is_load &&
                (bus.ex_rd != {AW{1'b0}}) &&
                ((bus.id_rs_used && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_rt_used && (bus.id_rt == bus.ex_rd)));

  // WAW on id_rd keeps a second long-latency write from racing the first
  assign sb_s = bus.id_valid &&
                ((bus.id_rs_used && busy_s[bus.id_rs]) ||
                 (bus.id_rt_used && busy_s[bus.id_rt]) ||
                 (bus.id_we      && busy_s[bus.id_rd]));

  assign stall_s  = lu_s || sb_s;
  assign set_en_s = bus.id_valid && bus.id_is_ll && bus.id_we && !stall_s &&
                    (bus.id_rd != {AW{1'b0}});

  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en_s),
    .set_idx (bus.id_rd),
    .clr_en  (bus.ll_done_valid),
    .clr_idx (bus.ll_done_rd),
    .busy    (busy_s)
  );

  // Hazard FSM next state: every state follows the same rule, sb over lu
  always_comb begin
    state_nxt_s = RUN;
    case (state_r)
      RUN, LU_STALL, SB_WAIT: state_nxt_s = sb_s ? SB_WAIT : (lu_s ? LU_STALL : RUN);
      default:                state_nxt_s = RUN;
    endcase
  end

  // Hazard FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_r;
  logic [CNT_W-1:0] sb_cnt_r;

  // Saturating stall-cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_r <= {CNT_W{1'b0}};
      sb_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (lu_s && !sb_s) begin
        lu_cnt_r <= sat_inc(lu_cnt_r);
      end
      if (sb_s) begin
        sb_cnt_r <= sat_inc(sb_cnt_r);
      end
    end
  end

  assign bus.lu_stall_cnt = lu_cnt_r;
  assign bus.sb_stall_cnt = sb_cnt_r;
`else
  assign bus.lu_stall_cnt = {CNT_W{1'b0}};
  assign bus.sb_stall_cnt = {CNT_W{1'b0}};
`endif

  assign bus.fwd_sel_a = fwd_a_s;
  assign bus.fwd_sel_b = fwd_b_s;
  assign bus.stall     = stall_s;
  assign bus.hz_state  = state_r;
  assign bus.sb_busy   = busy_s;

endmodule
